// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (CPU and debug/loader) in front of a single-port synchronous word memory.
// Each transaction runs IDLE -> ACCESS -> CAPTURE -> RESP; every output is registered.
module mem_port_arbiter #(
    parameter int DEPTH        = 1024,
    parameter int AW           = 10,
    parameter bit DBG_PRIORITY = 1'b0
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [31:0]   cpu_addr,
    input  logic [3:0]    cpu_be,
    input  logic [31:0]   cpu_wdata,
    output logic          cpu_ack,
    output logic [31:0]   cpu_rdata,
    output logic          cpu_err,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [31:0]   dbg_addr,
    input  logic [3:0]    dbg_be,
    input  logic [31:0]   dbg_wdata,
    output logic          dbg_ack,
    output logic [31:0]   dbg_rdata,
    output logic          dbg_err,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_be,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic [15:0]   contention_cnt
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_CAPTURE,
        ST_RESP
    } state_t;

    localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH) << 2;

    state_t r_state;
    state_t w_state_next;

    logic        r_last_dbg;
    logic        r_win_dbg;
    logic        r_oor;
    logic        r_rd;

    logic        w_grant;
    logic        w_both;
    logic        w_pick_dbg;
    logic        w_sel_we;
    logic        w_sel_oor;
    logic [31:0] w_sel_addr;
    logic [3:0]  w_sel_be;
    logic [31:0] w_sel_wdata;
    logic [31:0] w_cap_data;

    assign w_grant = (r_state == ST_IDLE) && (cpu_req || dbg_req);
    assign w_both  = cpu_req && dbg_req;

    // On a tie the debug side wins if it has priority or if the CPU was served last.
    assign w_pick_dbg  = dbg_req && (!cpu_req || DBG_PRIORITY || !r_last_dbg);
    assign w_sel_we    = w_pick_dbg ? dbg_we    : cpu_we;
    assign w_sel_addr  = w_pick_dbg ? dbg_addr  : cpu_addr;
    assign w_sel_be    = w_pick_dbg ? dbg_be    : cpu_be;
    assign w_sel_wdata = w_pick_dbg ? dbg_wdata : cpu_wdata;
    assign w_sel_oor   = (w_sel_addr >= ADDR_LIMIT);
    assign w_cap_data  = (r_rd && !r_oor) ? mem_rdata : 32'h0;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (cpu_req || dbg_req) w_state_next = ST_ACCESS;
            ST_ACCESS:  w_state_next = ST_CAPTURE;
            ST_CAPTURE: w_state_next = ST_RESP;
            ST_RESP:    w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_last_dbg     <= 1'b1;
            r_win_dbg      <= 1'b0;
            r_oor          <= 1'b0;
            r_rd           <= 1'b0;
            mem_en         <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_be         <= 4'h0;
            mem_wdata      <= 32'h0;
            cpu_ack        <= 1'b0;
            cpu_rdata      <= 32'h0;
            cpu_err        <= 1'b0;
            dbg_ack        <= 1'b0;
            dbg_rdata      <= 32'h0;
            dbg_err        <= 1'b0;
            contention_cnt <= 16'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_win_dbg  <= w_pick_dbg;
                        r_last_dbg <= w_pick_dbg;
                        r_oor      <= w_sel_oor;
                        r_rd       <= !w_sel_we;
                        mem_en     <= !w_sel_oor;
                        mem_we     <= w_sel_we;
                        mem_addr   <= w_sel_addr[AW+1:2];
                        mem_be     <= w_sel_we ? w_sel_be : 4'h0;
                        mem_wdata  <= w_sel_wdata;
                        if (w_both && (contention_cnt != 16'hFFFF)) begin
                            contention_cnt <= contention_cnt + 16'd1;
                        end
                    end
                end
                ST_ACCESS: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                end
                ST_CAPTURE: begin
                    if (r_win_dbg) begin
                        dbg_ack   <= 1'b1;
                        dbg_rdata <= w_cap_data;
                        dbg_err   <= r_oor;
                    end else begin
                        cpu_ack   <= 1'b1;
                        cpu_rdata <= w_cap_data;
                        cpu_err   <= r_oor;
                    end
                end
                ST_RESP: begin
                    cpu_ack   <= 1'b0;
                    cpu_rdata <= 32'h0;
                    cpu_err   <= 1'b0;
                    dbg_ack   <= 1'b0;
                    dbg_rdata <= 32'h0;
                    dbg_err   <= 1'b0;
                end
                default: begin
                    mem_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a word-array reference model predicts grants, read data,
// errors and contention count for every transaction; a second instance exercises debug priority.
module tb_mem_port_arbiter;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        cpu_req, cpu_we, dbg_req, dbg_we;
    logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
    logic [3:0]  cpu_be, dbg_be;
    logic        cpu_ack, cpu_err, dbg_ack, dbg_err;
    logic [31:0] cpu_rdata, dbg_rdata;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic [15:0] contention_cnt;

    // Priority instance signals
    logic        p_cpu_req, p_dbg_req;
    logic [31:0] p_cpu_addr, p_dbg_addr;
    logic        p_cpu_ack, p_cpu_err, p_dbg_ack, p_dbg_err;
    logic [31:0] p_cpu_rdata, p_dbg_rdata;
    logic        p_mem_en, p_mem_we;
    logic [9:0]  p_mem_addr;
    logic [3:0]  p_mem_be;
    logic [31:0] p_mem_wdata;
    logic [31:0] p_mem_rdata = 32'h0;
    logic [15:0] p_contention_cnt;

    logic [31:0] ram     [0:1023] = '{default: 32'h0};
    logic [31:0] ref_mem [0:1023] = '{default: 32'h0};

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_txn    = 0;
    bit          m_last_dbg;
    logic [15:0] m_cnt;

    always #5 clock = ~clock;

    mem_port_arbiter #(.DEPTH(1024), .AW(10), .DBG_PRIORITY(1'b0)) u_dut (
        .clock(clock), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_be(cpu_be),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_be(dbg_be),
        .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .contention_cnt(contention_cnt)
    );

    mem_port_arbiter #(.DEPTH(1024), .AW(10), .DBG_PRIORITY(1'b1)) u_dut_p (
        .clock(clock), .reset_n(reset_n),
        .cpu_req(p_cpu_req), .cpu_we(1'b0), .cpu_addr(p_cpu_addr), .cpu_be(4'h0),
        .cpu_wdata(32'h0), .cpu_ack(p_cpu_ack), .cpu_rdata(p_cpu_rdata), .cpu_err(p_cpu_err),
        .dbg_req(p_dbg_req), .dbg_we(1'b0), .dbg_addr(p_dbg_addr), .dbg_be(4'h0),
        .dbg_wdata(32'h0), .dbg_ack(p_dbg_ack), .dbg_rdata(p_dbg_rdata), .dbg_err(p_dbg_err),
        .mem_en(p_mem_en), .mem_we(p_mem_we), .mem_addr(p_mem_addr), .mem_be(p_mem_be),
        .mem_wdata(p_mem_wdata), .mem_rdata(p_mem_rdata), .contention_cnt(p_contention_cnt)
    );

    // Synchronous single-port memory with byte enables
    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
            mem_rdata <= ram[mem_addr];
        end
    end

    // Priority instance reads back its own word address
    always @(posedge clock) begin
        if (p_mem_en) p_mem_rdata <= {22'h0, p_mem_addr};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(9, 0);
        if (r == 0) return 32'h1000 + (32'($urandom) & 32'h000F_FFFF);
        if (r == 1) return 32'h0000_0FFC;
        return (32'($urandom_range(15, 0)) << 2) | 32'($urandom_range(3, 0));
    endfunction

    task automatic set_cpu(input logic we, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_be = be; cpu_wdata = wd;
    endtask

    task automatic set_dbg(input logic we, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
        dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_be = be; dbg_wdata = wd;
    endtask

    function automatic logic [3:0] rand_be(input logic we);
        if (we && $urandom_range(1, 0) == 1) return 4'b0001 << $urandom_range(3, 0);
        if (we) return 4'hF;
        return 4'($urandom);
    endfunction

    task automatic rand_cpu();
        logic we;
        we = 1'($urandom_range(1, 0));
        set_cpu(we, rand_addr(), rand_be(we), $urandom);
    endtask

    task automatic rand_dbg();
        logic we;
        we = 1'($urandom_range(1, 0));
        set_dbg(we, rand_addr(), rand_be(we), $urandom);
    endtask

    // Called with the DUT in IDLE, 1 time unit after an edge; returns after the RESP edge.
    task automatic run_grant(output bit win_dbg, output logic [31:0] obs_rd);
        bit          both, we_s, oor;
        logic [31:0] a, wd, exp_rd;
        logic [3:0]  be_s;
        both = cpu_req && dbg_req;
        win_dbg = both ? !m_last_dbg : dbg_req;
        if (both && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        m_last_dbg = win_dbg;
        a    = win_dbg ? dbg_addr  : cpu_addr;
        we_s = win_dbg ? dbg_we    : cpu_we;
        be_s = win_dbg ? dbg_be    : cpu_be;
        wd   = win_dbg ? dbg_wdata : cpu_wdata;
        oor  = (a >= 32'h1000);
        exp_rd = 32'h0;
        if (!oor) begin
            if (we_s) begin
                for (int b = 0; b < 4; b++) begin
                    if (be_s[b]) ref_mem[a[11:2]][8*b +: 8] = wd[8*b +: 8];
                end
            end else begin
                exp_rd = ref_mem[a[11:2]];
            end
        end
        @(posedge clock); #1;
        check("mem_en", mem_en, !oor);
        check("mem_be", mem_be, we_s ? be_s : 4'h0);
        check("cnt", contention_cnt, m_cnt);
        if (!oor) begin
            check("mem_addr", mem_addr, a[11:2]);
            check("mem_we", mem_we, we_s);
            if (we_s) check("mem_wdata", mem_wdata, wd);
        end
        @(posedge clock); #1;
        check("early_ack", {cpu_ack, dbg_ack}, 2'b00);
        check("en_clr", {mem_en, mem_we}, 2'b00);
        @(posedge clock); #1;
        check("ack_win", win_dbg ? dbg_ack : cpu_ack, 1'b1);
        check("ack_lose", win_dbg ? cpu_ack : dbg_ack, 1'b0);
        obs_rd = win_dbg ? dbg_rdata : cpu_rdata;
        check("rdata", obs_rd, exp_rd);
        check("err", win_dbg ? dbg_err : cpu_err, oor);
        $display("TXN %0d %s we=%0d addr=%h rdata=%h err=%0d cnt=%0d", n_txn,
                 win_dbg ? "DBG" : "CPU", we_s, a, obs_rd, oor, contention_cnt);
        n_txn++;
        @(posedge clock); #1;
        check("ack_clr", {cpu_ack, dbg_ack, cpu_err, dbg_err}, 4'h0);
        check("rdata_clr", cpu_rdata | dbg_rdata, 32'h0);
    endtask

    task automatic drop(input bit win_dbg);
        if (win_dbg) dbg_req = 1'b0; else cpu_req = 1'b0;
    endtask

    initial begin
        bit          w;
        logic [31:0] rd;
        reset_n = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_be = 0; cpu_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_be = 0; dbg_wdata = 0;
        p_cpu_req = 0; p_dbg_req = 0; p_cpu_addr = 0; p_dbg_addr = 0;
        m_last_dbg = 1'b1; m_cnt = 16'h0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_flags", {cpu_ack, dbg_ack, cpu_err, dbg_err, mem_en, mem_we, mem_be}, 10'h0);
        check("rst_rdata", cpu_rdata | dbg_rdata | mem_wdata, 32'h0);
        check("rst_addr", mem_addr, 10'h0);
        check("rst_cnt", contention_cnt, 16'h0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        // Loader preloads, then the CPU fetch and a sub-word debug write
        set_dbg(1, 32'h8, 4'hF, 32'h8C08_0010);  run_grant(w, rd); drop(w);
        set_dbg(1, 32'h40, 4'hF, 32'h1122_3344); run_grant(w, rd); drop(w);
        set_cpu(0, 32'h8, 4'h0, 32'h0);          run_grant(w, rd); drop(w);
        check("tp_fetch", rd, 32'h8C08_0010);
        set_dbg(1, 32'h40, 4'b0010, 32'h0000_AB00); run_grant(w, rd); drop(w);
        check("tp_sb_rdata", rd, 32'h0);
        set_dbg(0, 32'h40, 4'h0, 32'h0);         run_grant(w, rd); drop(w);
        check("tp_sb_merge", rd, 32'h1122_AB44);

        // Both held for four transactions: alternate starting with the CPU
        rand_cpu(); rand_dbg();
        for (int i = 0; i < 4; i++) begin
            run_grant(w, rd);
            check("rr_grant", w, i % 2);
            if (i < 3) begin
                if (w) rand_dbg(); else rand_cpu();
            end else begin
                drop(w);
            end
        end
        run_grant(w, rd); drop(w);
        check("rr_cnt", contention_cnt, 16'd4);

        // Address-range boundary
        set_cpu(0, 32'h1000, 4'hF, 32'h0);          run_grant(w, rd); drop(w);
        set_cpu(1, 32'h1000, 4'hF, 32'hFFFF_FFFF);  run_grant(w, rd); drop(w);
        set_cpu(1, 32'hFFC, 4'hF, 32'hDEAD_BEEF);   run_grant(w, rd); drop(w);
        set_dbg(0, 32'hFFC, 4'h0, 32'h0);           run_grant(w, rd); drop(w);
        check("last_word", rd, 32'hDEAD_BEEF);
        set_dbg(0, 32'hFFFF_FFFC, 4'h0, 32'h0);     run_grant(w, rd); drop(w);

        for (int i = 0; i < 60; i++) begin
            if (!cpu_req && $urandom_range(1, 0) == 1) rand_cpu();
            if (!dbg_req && $urandom_range(1, 0) == 1) rand_dbg();
            if (!cpu_req && !dbg_req) rand_cpu();
            run_grant(w, rd);
            drop(w);
        end
        for (int i = 0; i < 2; i++) begin
            if (cpu_req || dbg_req) begin
                run_grant(w, rd); drop(w);
            end
        end

        // Reset landing on the ACCESS edge: the write still strobes, but no ack follows
        set_dbg(1, 32'h24, 4'hF, 32'h0BAD_F00D); run_grant(w, rd); drop(w);
        set_cpu(1, 32'h20, 4'hF, 32'hA5A5_5A5A);
        @(posedge clock); #1;
        check("rst_pre_en", mem_en, 1'b1);
        reset_n = 1'b0; cpu_req = 1'b0;
        m_last_dbg = 1'b1; m_cnt = 16'h0;
        ref_mem[8] = 32'hA5A5_5A5A;
        @(posedge clock); #1;
        check("rst_mid_en", mem_en, 1'b0);
        check("rst_mid_cnt", contention_cnt, 16'h0);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            check("rst_mid_noack", {cpu_ack, dbg_ack, mem_en}, 3'b000);
        end
        // Reset sampled together with the request: nothing reaches memory
        set_cpu(1, 32'h24, 4'hF, 32'h5555_AAAA);
        reset_n = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1; cpu_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rst_e0_noack", {cpu_ack, dbg_ack, mem_en}, 3'b000);
            @(posedge clock); #1;
        end
        set_cpu(0, 32'h20, 4'h0, 32'h0);
        set_dbg(0, 32'h24, 4'h0, 32'h0);
        run_grant(w, rd);
        check("rst_first_tie", w, 1'b0);
        check("rst_wr_landed", rd, 32'hA5A5_5A5A);
        drop(w);
        run_grant(w, rd); drop(w);
        check("rst_wr_blocked", rd, 32'h0BAD_F00D);

        // Debug-priority instance: debug wins every tie while it keeps requesting
        p_cpu_req = 1'b1; p_cpu_addr = 32'h10;
        p_dbg_req = 1'b1; p_dbg_addr = 32'h20;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            check("p_en", p_mem_en, 1'b1);
            @(posedge clock); @(posedge clock); #1;
            check("p_dbg_ack", p_dbg_ack, 1'b1);
            check("p_cpu_ack", p_cpu_ack, 1'b0);
            check("p_dbg_rdata", p_dbg_rdata, p_dbg_addr >> 2);
            check("p_cnt", p_contention_cnt, 16'(i + 1));
            $display("TXN P%0d DBG addr=%h rdata=%h cnt=%0d", i, p_dbg_addr, p_dbg_rdata, p_contention_cnt);
            @(posedge clock); #1;
            p_dbg_addr = p_dbg_addr + 32'h4;
        end
        p_dbg_req = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("p_cpu_ack_last", p_cpu_ack, 1'b1);
        check("p_cpu_rdata", p_cpu_rdata, 32'h4);
        check("p_cnt_final", p_contention_cnt, 16'd3);
        $display("TXN P3 CPU addr=%h rdata=%h cnt=%0d", p_cpu_addr, p_cpu_rdata, p_contention_cnt);
        p_cpu_req = 1'b0;
        @(posedge clock); #1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
